// File: rtl/energy_logger_pkg.sv
// Shared widths, record layout and sample conversion
// for the multi-channel energy logger.
package energy_logger_pkg;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int rec_peak_lsb(input int dw);
    return dw;
  endfunction

  function automatic int rec_ch_lsb(input int dw);
    return 2 * dw;
  endfunction

  // (x*gain)>>shift clamped to the dw-bit maximum
  function automatic logic [31:0] sat_conv(
    input logic [31:0] x,
    input int          gain,
    input int          shift,
    input int          dw
  );
    logic [31:0] p;
    logic [31:0] mx;
    p  = (x * 32'(gain)) >> shift;
    mx = (32'd1 << dw) - 32'd1;
    return (p > mx) ? mx : p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous record FIFO with occupancy count;
// FWFT shows the head, otherwise data lands on pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter bit FWFT  = 1'b1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             pop;
  logic             wr_en;

  assign rd_valid = (cnt_q != '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign count    = cnt_q;
  assign pop      = rd_valid & rd_ready;
  // a pop frees the slot in the same edge
  assign wr_en    = push & (~full | pop);
  assign rdata    = (FWFT && rd_valid) ? mem_q[rd_ptr_q] : hold_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (FWFT) begin
      if (rd_valid) hold_d = mem_q[rd_ptr_q];
    end else if (pop) begin
      hold_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/energy_channel_logger.sv
// Per-channel boost conversion, windowed avg/peak
// accumulation and buffered record readout.
module energy_channel_logger
  import energy_logger_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = ch_w(NUM_CH),
  parameter int WIN_LOG2   = 4,
  parameter int GAIN       = 3,
  parameter int GAIN_SHIFT = 1,
  parameter int FIFO_DEPTH = 8,
  localparam int REC_W = CH_W + 2 * DATA_W,
  localparam int CNT_W = cnt_w(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [REC_W-1:0]  rd_data,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [7:0]        drop_cnt
);

  localparam int IDX_W    = ch_w(NUM_CH);
  localparam int SUM_W    = DATA_W + WIN_LOG2;
  localparam int PEAK_LSB = rec_peak_lsb(DATA_W);
  localparam int CH_LSB   = rec_ch_lsb(DATA_W);

  logic              s1_valid_q, s1_valid_d;
  logic [CH_W-1:0]   s1_ch_q, s1_ch_d;
  logic [DATA_W-1:0] s1_conv_q, s1_conv_d;

  always_comb begin
    s1_valid_d = in_valid && (32'(in_ch) < NUM_CH);
    s1_ch_d    = in_ch;
    s1_conv_d  = DATA_W'(sat_conv(32'(in_data), GAIN,
                                  GAIN_SHIFT, DATA_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_conv_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ch_q    <= s1_ch_d;
      s1_conv_q  <= s1_conv_d;
    end
  end

  logic [SUM_W-1:0]    sum_q  [NUM_CH];
  logic [SUM_W-1:0]    sum_d  [NUM_CH];
  logic [DATA_W-1:0]   peak_q [NUM_CH];
  logic [DATA_W-1:0]   peak_d [NUM_CH];
  logic [WIN_LOG2-1:0] cnt_q  [NUM_CH];
  logic [WIN_LOG2-1:0] cnt_d  [NUM_CH];

  logic [IDX_W-1:0]  idx;
  logic [SUM_W-1:0]  sum_nx;
  logic [DATA_W-1:0] peak_nx;
  logic              push;
  logic [REC_W-1:0]  rec;

  assign idx = IDX_W'(s1_ch_q);

  always_comb begin
    sum_d   = sum_q;
    peak_d  = peak_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    rec     = '0;
    sum_nx  = sum_q[idx] + SUM_W'(s1_conv_q);
    peak_nx = (s1_conv_q > peak_q[idx]) ? s1_conv_q
                                        : peak_q[idx];
    if (s1_valid_q) begin
      // last sample of the window: emit and restart
      if (&cnt_q[idx]) begin
        push                      = 1'b1;
        rec[CH_LSB +: CH_W]       = s1_ch_q;
        rec[PEAK_LSB +: DATA_W]   = peak_nx;
        rec[0 +: DATA_W]          = sum_nx[SUM_W-1 -: DATA_W];
        sum_d[idx]                = '0;
        peak_d[idx]               = '0;
        cnt_d[idx]                = '0;
      end else begin
        sum_d[idx]  = sum_nx;
        peak_d[idx] = peak_nx;
        cnt_d[idx]  = cnt_q[idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sum_q[i]  <= '0;
        peak_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      sum_q  <= sum_d;
      peak_q <= peak_d;
      cnt_q  <= cnt_d;
    end
  end

  logic full;
  logic drop;

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH),
    .FWFT  (1'b1)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .wdata    (rec),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rdata    (rd_data),
    .count    (fifo_count),
    .full     (full)
  );

  assign drop = push & full & ~(rd_valid & rd_ready);

  logic       ovf_q, ovf_d;
  logic [7:0] drop_q, drop_d;
  logic [7:0] drop_base;

  // a drop in the clearing cycle still counts
  always_comb begin
    drop_base = clr_ovf ? 8'd0 : drop_q;
    ovf_d     = clr_ovf ? 1'b0 : ovf_q;
    drop_d    = drop_base;
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = (&drop_base) ? drop_base : drop_base + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: doc/energy_channel_logger.md
Name: energy_channel_logger

Overview:
Parametrised successor to the single-path converter/collector pair. Accepts time-multiplexed raw samples from NUM_CH renewable sources, applies a fixed-point boost gain with saturation, and accumulates per-channel windowed average and peak. Completed window records are buffered in a FIFO and drained through a valid/ready read port. Sits between the input pin mux and the output/readout logic of the top-level tile.

Parameters:
DATA_W, 8, raw sample and converted value width
NUM_CH, 4, number of source channels (>=1); CH_W = max(1, clog2(NUM_CH))
WIN_LOG2, 4, window length = 2**WIN_LOG2 samples per channel
GAIN, 3, conversion multiplier (unsigned, 1..15)
GAIN_SHIFT, 1, conversion right shift; conv = (sample*GAIN) >> GAIN_SHIFT
FIFO_DEPTH, 8, record FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample strobe, one sample per cycle max
in_ch  in  CH_W  channel index of sample
in_data  in  DATA_W  raw sample
rd_valid  out  1  FIFO head record available
rd_ready  in  1  consumer accepts head record
rd_data  out  CH_W+2*DATA_W  record {ch, peak, avg}, ch in MSBs
fifo_count  out  clog2(FIFO_DEPTH)+1  records held
overflow  out  1  sticky: a record was dropped
clr_ovf  in  1  clears overflow
drop_cnt  out  8  dropped-record count, saturates at 255

Behaviour:
- Reset (async, rst_n=0): all accumulators, peaks, sample counters, FIFO pointers cleared; rd_valid=0, rd_data=0, fifo_count=0, overflow=0, drop_cnt=0. Reset mid-window discards partial windows; no record emitted.
- Stage 1 (cycle t, in_valid=1): conv = min((in_data*GAIN)>>GAIN_SHIFT, 2**DATA_W-1), product width DATA_W+4; registered with ch and valid at edge t.
- in_ch >= NUM_CH: sample ignored, no state change.
- Stage 2 (cycle t+1): channel ch: sum += conv (width DATA_W+WIN_LOG2, no overflow possible), peak = max(peak, conv), cnt += 1.
- Window close: when cnt reaches 2**WIN_LOG2-1 before the update, record {ch, peak', sum'>>WIN_LOG2} is pushed at edge t+1 and the channel's sum/peak/cnt clear to 0 in the same edge. Record visible on rd_valid at cycle t+2 if FIFO was empty (2-cycle latency sample-to-record).
- Channels are independent; interleaved samples allowed; at most one push per cycle by construction.
- FIFO: first-word-fall-through; rd_data = head while rd_valid=1; pop on rd_valid&rd_ready. rd_data holds value when rd_valid=0 (last head, 0 after reset).
- Full + push, no pop: record dropped, overflow<=1, drop_cnt++ (saturating). Full + push + pop same cycle: both succeed, count unchanged, no drop.
- Empty + push + rd_ready: no bypass; record appears next cycle.
- clr_ovf: clears overflow and drop_cnt; if a drop coincides, drop wins (overflow=1, drop_cnt=1).
- Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.

Decomposition:
- Package energy_logger_pkg: CH_W/count-width functions, record field offsets, saturating-convert function.
- Sub-module sync_fifo (parametrised WIDTH, DEPTH, FWFT, count output); conversion and per-channel accumulator bank stay in the top of this block.

Test Plan:
- Reset then 16 samples in_data=100 on ch2 -> rd_valid rises 2 cycles after 16th sample; rd_data={2,150,150}; fifo_count=1.
- 16 samples in_data=200 on ch0 -> conv saturates 300->255; record {0,255,255}.
- ch1 alternating 10/20, 16 samples, interleaved with ch3 samples -> ch1 record {1,30,22} (sum 360>>4); ch3 window unaffected.
- rd_ready=0, complete 9 windows -> fifo_count=8, overflow=1, drop_cnt=1; then push with simultaneous pop at full -> no further drop; clr_ovf -> overflow=0, drop_cnt=0.
- 10 samples on ch0, assert rst_n low mid-cycle, release, 16 samples of 50 -> single record {0,75,75}; no partial record.
- in_ch=5 with NUM_CH=4 (CH_W=3 override test) -> sample ignored, counters unchanged.
